// File: rtl/uart_pkg.sv
// Shared CoreUART constants and receive deframer state encoding.
// Used by both the receive buffer and the transmit side.
package uart_pkg;

  localparam int BITWIDTH   = 8;
  localparam int OVS        = 16;
  localparam int PARITY_ODD = 0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: DEPTH x WIDTH, registered read data, one cycle from pop to pop_dat_o.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign pop_dat_o = dat_q;

  assign do_pop  = pop_i && !empty;
  // A full buffer still accepts a byte when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dat_d    = dat_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dat_d    = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dat_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dat_q    <= dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive deframer + buffer; byte readable one cycle after its stop-bit sample, host pops via rRD.
// Full buffer drops new bytes (sticky rOverflow); optional parity check enabled by UART_RX_PARITY_EN.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                rClk,
  input  logic                rRst,
  input  logic                rBaudTick,
  input  logic                rRxd,
  input  logic                rRD,
  input  logic                rClrErr,
  output logic [BITWIDTH-1:0] rdataOut,
  output logic                rRxRdy,
  output logic                rFULL,
  output logic                rOverflow,
  output logic                rFramingErr,
  output logic                rParityErr
);

  localparam int TW  = $clog2(OVS);
  localparam int BCW = $clog2(BITWIDTH);
  localparam logic [TW-1:0]  HALF_TICK = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0]  LAST_TICK = TW'(OVS - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(BITWIDTH - 1);

  logic                sync1_q, sync2_q;
  logic                rxd;
  rx_state_e           state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [BCW-1:0]      bit_q, bit_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic                push, pop;
  logic                fe_set, ovf_set;
  logic                fe_q, ovf_q;
  logic                fifo_full;
  logic [$clog2(DEPTH):0] fifo_cnt;
`ifdef UART_RX_PARITY_EN
  logic                par_fail_q, par_fail_d;
  logic                pe_set;
  logic                pe_q;
`endif

  assign rxd = sync2_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_fail_d = par_fail_q;
    pe_set     = 1'b0;
`endif
    if (rBaudTick) begin
      case (state_q)
        IDLE: begin
          if (!rxd) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == HALF_TICK) begin
            tick_d = '0;
            bit_d  = '0;
`ifdef UART_RX_PARITY_EN
            par_fail_d = 1'b0;
`endif
            // A line that is high again at mid start bit was a glitch.
            state_d = rxd ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            shift_d = {rxd, shift_q[BITWIDTH-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            state_d = STOP;
            if (((^shift_q) ^ rxd) != 1'(PARITY_ODD)) begin
              par_fail_d = 1'b1;
              pe_set     = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_q == LAST_TICK) begin
            // Leaving at mid stop bit lets the next start edge be caught on time.
            state_d = IDLE;
            tick_d  = '0;
            if (rxd) begin
`ifdef UART_RX_PARITY_EN
              push = !par_fail_q;
`else
              push = 1'b1;
`endif
            end else begin
              fe_set = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  assign pop     = rRD && rRxRdy;
  assign ovf_set = push && fifo_full && !pop;

  always_ff @(posedge rClk) begin
    if (rRst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= rRxd;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fe_q    <= fe_set | (fe_q & ~rClrErr);
      ovf_q   <= ovf_set | (ovf_q & ~rClrErr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge rClk) begin
    if (rRst) begin
      par_fail_q <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      par_fail_q <= par_fail_d;
      pe_q       <= pe_set | (pe_q & ~rClrErr);
    end
  end
  assign rParityErr = pe_q;
`else
  assign rParityErr = 1'b0;
`endif

  uart_rx_fifo #(
    .WIDTH (BITWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (rClk),
    .rst_i      (rRst),
    .push_i     (push),
    .push_dat_i (shift_q),
    .pop_i      (pop),
    .pop_dat_o  (rdataOut),
    .full_o     (fifo_full),
    .count_o    (fifo_cnt)
  );

  assign rRxRdy      = (fifo_cnt != '0);
  assign rFULL       = fifo_full;
  assign rOverflow   = ovf_q;
  assign rFramingErr = fe_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: serial frames in, scoreboard of expected bytes out.
// Baud tick runs every second clock so one bit spans 32 clocks.
module tb_uart_rx_buffer;

  localparam int DEPTH  = 4;
  localparam int BITCYC = 2 * uart_pkg::OVS;

  logic       clk;
  logic       rRst, rBaudTick, rRxd, rRD, rClrErr;
  logic [7:0] rdataOut;
  logic       rRxRdy, rFULL, rOverflow, rFramingErr, rParityErr;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic       ph     = 1'b0;
  logic [7:0] exp_q[$];
  int         model_cnt = 0;
  logic       exp_ovf   = 1'b0;
  logic [7:0] last_rd   = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic       bad_par   = 1'b0;
`endif

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .rClk        (clk),
    .rRst        (rRst),
    .rBaudTick   (rBaudTick),
    .rRxd        (rRxd),
    .rRD         (rRD),
    .rClrErr     (rClrErr),
    .rdataOut    (rdataOut),
    .rRxRdy      (rRxRdy),
    .rFULL       (rFULL),
    .rOverflow   (rOverflow),
    .rFramingErr (rFramingErr),
    .rParityErr  (rParityErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    ph = ~ph;
    rBaudTick = ph;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send_bit(input logic b);
    rRxd = b;
    idle(BITCYC);
  endtask

  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ (uart_pkg::PARITY_ODD != 0) ^ bad_par);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_head(d);
    send_bit(stop);
    rRxd = 1'b1;
  endtask

  // Scoreboard model of a byte that should land in the buffer.
  task automatic expect_push(input logic [7:0] d);
    if (model_cnt < DEPTH) begin
      exp_q.push_back(d);
      model_cnt++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic rd_check(input string tag);
    logic [7:0] e;
    check({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (model_cnt > 0) model_cnt--;
    rRD = 1'b1;
    cyc();
    rRD = 1'b0;
    check(tag, 32'(rdataOut), 32'(e));
    last_rd = e;
  endtask

  task automatic clr_err();
    rClrErr = 1'b1;
    cyc();
    rClrErr = 1'b0;
    exp_ovf = 1'b0;
  endtask

  initial begin
    rRst = 1'b1; rBaudTick = 1'b0; rRxd = 1'b1; rRD = 1'b0; rClrErr = 1'b0;
    idle(4);
    rRst = 1'b0;
    cyc();
    check("rst_data",  32'(rdataOut),    32'h0);
    check("rst_rdy",   32'(rRxRdy),      32'h0);
    check("rst_full",  32'(rFULL),       32'h0);
    check("rst_ovf",   32'(rOverflow),   32'h0);
    check("rst_fe",    32'(rFramingErr), 32'h0);
    check("rst_pe",    32'(rParityErr),  32'h0);
    idle(20);

    // Single frame: ready must appear after mid stop bit, not before.
    send_head(8'hA5);
    expect_push(8'hA5);
    rRxd = 1'b1;
    idle(12);
    check("a5_rdy_early", 32'(rRxRdy), 32'h0);
    idle(BITCYC - 12);
    check("a5_rdy", 32'(rRxRdy), 32'h1);
    rd_check("a5_data");
    check("a5_rdy_after", 32'(rRxRdy), 32'h0);
    rRD = 1'b1;
    cyc();
    rRD = 1'b0;
    check("empty_rd_hold", 32'(rdataOut), 32'(last_rd));

    // Short low pulse is a glitch.
    rRxd = 1'b0;
    idle(8);
    rRxd = 1'b1;
    idle(3 * BITCYC);
    check("glitch_rdy", 32'(rRxRdy),      32'h0);
    check("glitch_fe",  32'(rFramingErr), 32'h0);
    check("glitch_ovf", 32'(rOverflow),   32'h0);
    check("glitch_pe",  32'(rParityErr),  32'h0);

    // Back-to-back frames overrun the buffer.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      expect_push(8'(i));
    end
    idle(8);
    check("bb_full", 32'(rFULL),     32'(model_cnt == DEPTH));
    check("bb_ovf",  32'(rOverflow), 32'(exp_ovf));
    check("bb_rdy",  32'(rRxRdy),    32'(model_cnt != 0));
    for (int i = 0; i < DEPTH; i++) rd_check($sformatf("bb_data%0d", i));
    check("bb_rdy_drained",  32'(rRxRdy), 32'h0);
    check("bb_full_drained", 32'(rFULL),  32'h0);
    check("bb_ovf_sticky",   32'(rOverflow), 32'h1);
    clr_err();
    check("bb_ovf_clr", 32'(rOverflow), 32'(exp_ovf));

    // Bad stop bit drops the byte.
    send_frame(8'h3C, 1'b0);
    idle(2 * BITCYC);
    check("fe_set", 32'(rFramingErr), 32'h1);
    check("fe_rdy", 32'(rRxRdy),      32'h0);
    clr_err();
    check("fe_clr", 32'(rFramingErr), 32'h0);

`ifdef UART_RX_PARITY_EN
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    bad_par = 1'b0;
    idle(BITCYC);
    check("pe_set", 32'(rParityErr), 32'h1);
    check("pe_rdy", 32'(rRxRdy),     32'h0);
    clr_err();
    check("pe_clr", 32'(rParityErr), 32'h0);
    send_frame(8'h07, 1'b1);
    expect_push(8'h07);
    idle(8);
    rd_check("pe_good_data");
    check("pe_good_flag", 32'(rParityErr), 32'h0);
`endif

    // Reset in the middle of the data bits aborts the frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rRst = 1'b1;
    idle(2);
    rRst = 1'b0;
    rRxd = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    exp_ovf   = 1'b0;
    cyc();
    check("mid_rst_data", 32'(rdataOut), 32'h0);
    check("mid_rst_rdy",  32'(rRxRdy),   32'h0);
    idle(2 * BITCYC);
    send_frame(8'h5A, 1'b1);
    expect_push(8'h5A);
    idle(8);
    check("mid_rst_rdy2", 32'(rRxRdy), 32'h1);
    rd_check("mid_rst_5a");
    check("mid_rst_only", 32'(rRxRdy),      32'h0);
    check("mid_rst_fe",   32'(rFramingErr), 32'h0);
    check("mid_rst_ovf",  32'(rOverflow),   32'h0);
    check("mid_rst_pe",   32'(rParityErr),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
